// File: rtl/bcd_to_bin_seq.sv
// Sequential 4-digit BCD to binary converter using reverse double-dabble, one iteration per clock.
// Optional signed output enabled by defining BCD2BIN_SIGN_EN (adds the sign input).
module bcd_to_bin_seq #(
  parameter int unsigned OUT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [3:0]       q,
  input  logic [3:0]       b,
  input  logic [3:0]       s,
  input  logic [3:0]       g,
`ifdef BCD2BIN_SIGN_EN
  input  logic             sign,
`endif
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [OUT_W-1:0] binary
);

  localparam int unsigned BIN_W  = 14;
  localparam int unsigned BCD_W  = 16;
  localparam int unsigned WORK_W = BCD_W + BIN_W;
  localparam int unsigned ITERS  = 14;
  localparam int unsigned CNT_W  = 4;

  typedef enum logic {
    IDLE = 1'b0,
    CONV = 1'b1
  } state_t;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [WORK_W-1:0]   work_q, work_d;
  logic                invalid_q, invalid_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                err_q, err_d;
  logic [OUT_W-1:0]    binary_q, binary_d;
`ifdef BCD2BIN_SIGN_EN
  logic                sign_q, sign_d;
`endif

  logic [WORK_W-1:0]   step_c;
  logic [OUT_W-1:0]    mag_c;

  // One reverse double-dabble iteration: shift right, then pull every BCD nibble >= 8 down by 3.
  function automatic logic [WORK_W-1:0] dabble_step(input logic [WORK_W-1:0] w);
    logic [WORK_W-1:0] r;
    r = w >> 1;
    for (int i = 0; i < 4; i++) begin
      if (r[BIN_W + 4*i +: 4] >= 4'd8) begin
        r[BIN_W + 4*i +: 4] = r[BIN_W + 4*i +: 4] - 4'd3;
      end
    end
    return r;
  endfunction

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    work_d    = work_q;
    invalid_d = invalid_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    err_d     = err_q;
    binary_d  = binary_q;
`ifdef BCD2BIN_SIGN_EN
    sign_d    = sign_q;
`endif
    step_c    = dabble_step(work_q);
    mag_c     = OUT_W'(step_c[BIN_W-1:0]);

    case (state_q)
      IDLE: begin
        if (start) begin
          work_d    = {q, b, s, g, BIN_W'(0)};
          invalid_d = (q > 4'd9) || (b > 4'd9) || (s > 4'd9) || (g > 4'd9);
`ifdef BCD2BIN_SIGN_EN
          sign_d    = sign;
`endif
          cnt_d     = '0;
          busy_d    = 1'b1;
          state_d   = CONV;
        end
      end
      CONV: begin
        work_d = step_c;
        cnt_d  = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(ITERS - 1)) begin
          state_d = IDLE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          err_d   = invalid_q;
          if (invalid_q) begin
            binary_d = '0;
          end else begin
`ifdef BCD2BIN_SIGN_EN
            binary_d = sign_q ? OUT_W'(-mag_c) : mag_c;
`else
            binary_d = mag_c;
`endif
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      work_q    <= '0;
      invalid_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      binary_q  <= '0;
`ifdef BCD2BIN_SIGN_EN
      sign_q    <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      work_q    <= work_d;
      invalid_q <= invalid_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      err_q     <= err_d;
      binary_q  <= binary_d;
`ifdef BCD2BIN_SIGN_EN
      sign_q    <= sign_d;
`endif
    end
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign err    = err_q;
  assign binary = binary_q;

endmodule
